udalt_sweep_ctrl: RTL and testbench
===================================

# udalt_sweep_ctrl

Sequencing controller for the 4-bit up/down counter. It takes a start command with lower/upper bounds and a sweep count, preloads the counter, and drives its enable and direction so the count ramps lo→hi→lo for N full sweeps. It then pulses `done`. It sits between the control/test logic and the counter instance, and is the only driver of the counter's control inputs.

## Interface
Parameters:
- `WIDTH`, default 4: counter and bound width.
- `SWEEP_W`, default 4: width of the sweep count and sweep index.

Ports:
- `Clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `start`  in  1: command strobe; sampled only in IDLE.
- `lo`  in  WIDTH: lower bound; captured when `start` is accepted.
- `hi`  in  WIDTH: upper bound; captured when `start` is accepted.
- `sweeps`  in  SWEEP_W: number of full lo→hi→lo sweeps; captured when `start` is accepted.
- `hold`  in  1: pause; freezes counting while high in UP or DOWN.
- `abort`  in  1: synchronous abort; highest priority after `reset`.
- `count`  in  WIDTH: counter output feedback.
- `cnt_en`  out  1: counter enable.
- `cnt_up`  out  1: direction (1 = increment).
- `cnt_load`  out  1: synchronous preload strobe.
- `cnt_load_val`  out  WIDTH: preload value.
- `pos`  out  WIDTH: internal mirror of the expected counter value.
- `sweep_idx`  out  SWEEP_W: completed sweeps in the current run.
- `busy`  out  1: high in LOAD, UP and DOWN.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: sticky mismatch flag (see Configuration).

## Operation
- FSM states are IDLE, LOAD, UP, DOWN and DONE. Reset value is IDLE.
- Reset values: all outputs are 0, `pos`=0 and `sweep_idx`=0.
- **IDLE:**
  - On `start` with `lo<hi` (unsigned) and `sweeps`≠0: capture `lo`, `hi` and `sweeps`, clear `sweep_idx` and `err`, then go to LOAD.
  - On `start` with an invalid configuration: go directly to DONE. The counter is never touched.
- **LOAD** (exactly one cycle, ignores `hold`): `cnt_load`=1 and `cnt_load_val`=captured lo; `pos`←lo; next state is UP.
- **UP:** `cnt_up`=1 and `cnt_en`=!`hold`.
  - Each non-held cycle: `pos`←`pos`+1.
  - On the cycle where `pos`+1==hi is being applied, the next state is DOWN.
- **DOWN:** `cnt_up`=0 and `cnt_en`=!`hold`.
  - Each non-held cycle: `pos`←`pos`−1.
  - On the cycle where `pos`−1==lo is being applied: `sweep_idx`←`sweep_idx`+1.
  - The next state is DONE if `sweep_idx`+1==sweeps, otherwise UP.
- **DONE:** `done`=1 for one cycle, then IDLE. `pos` and `sweep_idx` hold their final values until the next accepted start.
- `cnt_load_val` = captured lo in LOAD, and 0 otherwise.
- `cnt_en`, `cnt_up` and `cnt_load` are decoded combinationally from the state register and `hold`. All other outputs are registered.
- `start` outside IDLE is ignored; there is no queueing.
- `abort` in any state: next state is IDLE and `cnt_en` is forced to 0 in the abort cycle. No `done` pulse; `pos` and `sweep_idx` are frozen.
  - `abort`+`start` together in IDLE: stay in IDLE.
- `reset` mid-run: the FSM returns to IDLE asynchronously and the counter control outputs drop at once. No `done` pulse.
- Arithmetic is unsigned modulo 2^WIDTH. Since lo<hi, `pos` never wraps during a valid run.

## Timing
- Let E0 be the edge that accepts `start` and D = hi−lo. With no holds:
  - LOAD occupies the cycle after E0.
  - The counter takes lo at the next edge.
  - Each sweep is D UP cycles followed by D DOWN cycles.
  - `done` is high for the cycle after edge E0+2·N·D+1.
- Each held cycle in UP or DOWN adds exactly one cycle of latency.
- Invalid configuration: `done` is high in the cycle after E0+1.
- `busy` rises after E0 and falls after the edge that enters DONE.

## Configuration
- `UDALT_SWEEP_CHECK_EN` defined:
  - In UP, DOWN and DONE, `count`≠`pos` sets `err` at the next edge.
  - `err` is sticky until the next accepted start or `reset`.
- Not defined: `err` is tied to 0 and `count` is unused.

## Test plan
- **Basic run:** reset, then start with lo=2, hi=5, sweeps=1.
  - LOAD with `cnt_load_val`=2.
  - `cnt_up`=1 for 3 enabled cycles, then 0 for 3 enabled cycles.
  - `done` after E0+7; `pos` ends at 2; `sweep_idx`=1.
- **Multi-sweep:** lo=0, hi=15, sweeps=3 → `pos` peaks at 15 three times, `done` after E0+91, `sweep_idx`=3.
- **Hold:** lo=2, hi=5, sweeps=1, with `hold` high for 2 cycles during UP → `cnt_en`=0 in those cycles, `pos` frozen, `done` after E0+9.
- **Invalid configuration:** start with lo=5, hi=5 (and separately sweeps=0) → `cnt_en` and `cnt_load` never assert, and `done` comes after E0+1.
- **Abort and reset:**
  - `abort` in the 2nd DOWN cycle → IDLE next cycle, no `done`.
  - A new start is then accepted normally.
  - `reset` pulsed mid-UP clears all outputs asynchronously.
- **Check (macro defined):** force `count` to differ from `pos` by 1 during UP → `err`=1 at the next edge. `err` stays set after `done` and clears on the next accepted start.

Source files
------------

// File: rtl/udalt_sweep_ctrl.sv
// udalt_sweep_ctrl: sequencing controller for the 4-bit up/down counter.
// Accepts a start command with lo/hi bounds and a sweep count, preloads the
// counter, ramps it lo->hi->lo for the requested number of sweeps and then
// pulses done. It is the sole driver of the counter's control inputs.
//
// Optional feature: define UDALT_SWEEP_CHECK_EN to compare the counter
// feedback against the internal position mirror and raise a sticky err flag.
// Without it, err is tied low and count is ignored.
module udalt_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 4
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] sweeps,
    input  logic               hold,
    input  logic               abort,
    input  logic [WIDTH-1:0]   count,
    output logic               cnt_en,
    output logic               cnt_up,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_load_val,
    output logic [WIDTH-1:0]   pos,
    output logic [SWEEP_W-1:0] sweep_idx,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_UP   = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [WIDTH-1:0]   POS_ONE = WIDTH'(1);
    localparam logic [SWEEP_W-1:0] IDX_ONE = SWEEP_W'(1);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   hi_r;
    logic [SWEEP_W-1:0] sweeps_r;
    logic               cfg_ok;
    logic               accept;
    logic               step;
    logic               in_run;
    logic [WIDTH-1:0]   pos_inc;
    logic [WIDTH-1:0]   pos_dec;
    logic [SWEEP_W-1:0] idx_inc;

    assign cfg_ok  = (lo < hi) && (sweeps != '0);
    assign accept  = (state == S_IDLE) && start && !abort;
    assign in_run  = (state == S_UP) || (state == S_DOWN);
    // A step is a cycle in which the counter actually moves.
    assign step    = in_run && !hold && !abort;
    assign pos_inc = pos + POS_ONE;
    assign pos_dec = pos - POS_ONE;
    assign idx_inc = sweep_idx + IDX_ONE;

    // Counter control strobes decode straight from state so they track hold/abort in the same cycle.
    always_comb begin
        cnt_en   = step;
        cnt_up   = (state == S_UP);
        cnt_load = (state == S_LOAD);
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = cfg_ok ? S_LOAD : S_DONE;
                    end
                end
                S_LOAD: state_nxt = S_UP;
                S_UP: begin
                    if (!hold && (pos_inc == hi_r)) begin
                        state_nxt = S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (!hold && (pos_dec == lo_r)) begin
                        state_nxt = (idx_inc == sweeps_r) ? S_DONE : S_UP;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register and captured command.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            lo_r     <= '0;
            hi_r     <= '0;
            sweeps_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept && cfg_ok) begin
                lo_r     <= lo;
                hi_r     <= hi;
                sweeps_r <= sweeps;
            end
        end
    end

    // Position mirror and completed-sweep index; both freeze on abort.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            pos       <= '0;
            sweep_idx <= '0;
        end else begin
            if ((state == S_LOAD) && !abort) begin
                pos <= lo_r;
            end else if (step) begin
                pos <= (state == S_UP) ? pos_inc : pos_dec;
            end
            if (accept && cfg_ok) begin
                sweep_idx <= '0;
            end else if (step && (state == S_DOWN) && (pos_dec == lo_r)) begin
                sweep_idx <= idx_inc;
            end
        end
    end

    // Registered status outputs. A run raises done on the edge entering DONE;
    // an invalid command spends its DONE cycle first, so its pulse lands one
    // edge later, after the FSM has already returned to IDLE.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            cnt_load_val <= '0;
        end else begin
            busy         <= (state_nxt == S_LOAD) || (state_nxt == S_UP) || (state_nxt == S_DOWN);
            done         <= !abort && (((state_nxt == S_DONE) && (state != S_IDLE)) ||
                                       ((state == S_DONE) && !done));
            cnt_load_val <= (state_nxt == S_LOAD) ? lo : '0;
        end
    end

`ifdef UDALT_SWEEP_CHECK_EN
    // Sticky mismatch flag between counter feedback and the expected position.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && cfg_ok) begin
            err <= 1'b0;
        end else if ((in_run || (state == S_DONE)) && (count != pos)) begin
            err <= 1'b1;
        end
    end
`else
    logic count_unused;
    assign count_unused = ^count;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_udalt_sweep_ctrl.sv
// Testbench for udalt_sweep_ctrl: directed scenarios plus randomized runs,
// checked cycle by cycle against a sweep model built from the bounds and
// sweep count (a queue of pending counter steps). A small behavioural
// up/down counter closes the feedback loop on count.
module tb_udalt_sweep_ctrl;

    localparam int WIDTH   = 4;
    localparam int SWEEP_W = 4;
`ifdef UDALT_SWEEP_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic               Clk;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [SWEEP_W-1:0] sweeps;
    logic               hold;
    logic               abort;
    logic [WIDTH-1:0]   count;
    logic               cnt_en;
    logic               cnt_up;
    logic               cnt_load;
    logic [WIDTH-1:0]   cnt_load_val;
    logic [WIDTH-1:0]   pos;
    logic [SWEEP_W-1:0] sweep_idx;
    logic               busy;
    logic               done;
    logic               err;

    logic [WIDTH-1:0]   cnt_model;
    logic [WIDTH-1:0]   tamper;

    int checks = 0;
    int errors = 0;

    // Values the model expects to persist between runs.
    logic [WIDTH-1:0]   last_pos = '0;
    logic [SWEEP_W-1:0] last_idx = '0;
    bit                 exp_err  = 1'b0;

    udalt_sweep_ctrl #(.WIDTH(WIDTH), .SWEEP_W(SWEEP_W)) dut (
        .Clk(Clk), .reset(reset), .start(start), .lo(lo), .hi(hi), .sweeps(sweeps),
        .hold(hold), .abort(abort), .count(count), .cnt_en(cnt_en), .cnt_up(cnt_up),
        .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .pos(pos), .sweep_idx(sweep_idx),
        .busy(busy), .done(done), .err(err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Stand-in for the real counter instance.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset)         cnt_model <= '0;
        else if (cnt_load) cnt_model <= cnt_load_val;
        else if (cnt_en)   cnt_model <= cnt_up ? cnt_model + 4'd1 : cnt_model - 4'd1;
    end
    assign count = cnt_model + tamper;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One valid run. hold_at >= 0 forces hold on run cycles hold_at and
    // hold_at+1; otherwise hold is random with hold_pct percent probability.
    // do_tamper skews count by one in the second UP cycle.
    task automatic run_valid(input logic [3:0] l, input logic [3:0] h, input logic [3:0] n,
                             input int hold_at, input int hold_pct, input bit do_tamper,
                             input int exp_lat);
        bit q[$];
        int d;
        int iter;
        int steps;
        int nholds;
        bit tampered;
        bit dir;
        logic [3:0] exp_pos;
        logic [3:0] exp_idx;
        d = int'(h) - int'(l);
        for (int s = 0; s < int'(n); s++) begin
            for (int k = 0; k < d; k++) q.push_back(1'b1);
            for (int k = 0; k < d; k++) q.push_back(1'b0);
        end
        start = 1'b1; lo = l; hi = h; sweeps = n; hold = 1'b0;
        tick();
        start = 1'b0;
        lo = 4'($urandom_range(0, 15)); hi = 4'($urandom_range(0, 15));
        sweeps = 4'($urandom_range(0, 15));
        hold = 1'($urandom_range(0, 1));
        exp_err = 1'b0;
        #1;
        chk("load_strobe", cnt_load, 1'b1);
        chk("load_val", cnt_load_val, l);
        chk("load_en", cnt_en, 1'b0);
        chk("load_busy", busy, 1'b1);
        chk("load_done", done, 1'b0);
        chk("load_idx", sweep_idx, 4'd0);
        chk("load_err", err, 1'b0);
        tick();
        exp_pos = l; exp_idx = 4'd0;
        iter = 0; steps = 0; nholds = 0; tampered = 1'b0;
        while (q.size() > 0 && iter < 2000) begin
            if (hold_at >= 0) hold = (iter == hold_at) || (iter == hold_at + 1);
            else              hold = ($urandom_range(0, 99) < hold_pct);
            tamper = (do_tamper && !tampered && q[0] && steps == 1) ? 4'd1 : 4'd0;
            #1;
            chk("run_en", cnt_en, !hold);
            chk("run_dir", cnt_up, q[0]);
            chk("run_pos", pos, exp_pos);
            chk("run_idx", sweep_idx, exp_idx);
            chk("run_busy", busy, 1'b1);
            chk("run_done", done, 1'b0);
            chk("run_load", cnt_load, 1'b0);
            chk("run_err", err, exp_err);
            tick();
            if (tamper != 4'd0) begin
                tampered = 1'b1;
                if (CHECK_EN) exp_err = 1'b1;
            end
            tamper = 4'd0;
            if (hold) begin
                nholds++;
            end else begin
                dir = q.pop_front();
                exp_pos = dir ? exp_pos + 4'd1 : exp_pos - 4'd1;
                steps++;
                if (steps % (2 * d) == 0) exp_idx = exp_idx + 4'd1;
            end
            iter++;
        end
        hold = 1'b0;
        chk("run_budget", q.size(), 0);
        #1;
        chk("end_done", done, 1'b1);
        chk("end_busy", busy, 1'b0);
        chk("end_pos", pos, l);
        chk("end_idx", sweep_idx, n);
        chk("end_en", cnt_en, 1'b0);
        chk("end_err", err, exp_err);
        chk("end_count", count, l);
        chk("latency", iter + 1, (exp_lat >= 0) ? exp_lat : 2 * int'(n) * d + 1 + nholds);
        tick();
        #1;
        chk("post_done", done, 1'b0);
        chk("post_pos", pos, l);
        chk("post_err", err, exp_err);
        last_pos = l;
        last_idx = n;
    endtask

    // Rejected command: counter untouched, done one cycle late, state kept.
    task automatic run_invalid(input logic [3:0] l, input logic [3:0] h, input logic [3:0] n);
        start = 1'b1; lo = l; hi = h; sweeps = n; hold = 1'b0;
        tick();
        start = 1'b0;
        #1;
        chk("inv_en0", cnt_en, 1'b0);
        chk("inv_load0", cnt_load, 1'b0);
        chk("inv_busy0", busy, 1'b0);
        chk("inv_done0", done, 1'b0);
        chk("inv_pos", pos, last_pos);
        chk("inv_idx", sweep_idx, last_idx);
        tick();
        #1;
        chk("inv_done1", done, 1'b1);
        chk("inv_en1", cnt_en, 1'b0);
        chk("inv_load1", cnt_load, 1'b0);
        chk("inv_lval", cnt_load_val, 4'd0);
        chk("inv_err", err, exp_err);
        tick();
        #1;
        chk("inv_done2", done, 1'b0);
    endtask

    initial begin
        logic [3:0] rl;
        logic [3:0] rh;
        logic [3:0] rn;
        reset = 1'b1; start = 1'b0; lo = '0; hi = '0; sweeps = '0;
        hold = 1'b0; abort = 1'b0; tamper = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_en", cnt_en, 1'b0);
        chk("rst_up", cnt_up, 1'b0);
        chk("rst_load", cnt_load, 1'b0);
        chk("rst_lval", cnt_load_val, 4'd0);
        chk("rst_pos", pos, 4'd0);
        chk("rst_idx", sweep_idx, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;
        tick();

        // Basic, multi-sweep and hold scenarios with fixed latencies.
        run_valid(4'd2, 4'd5, 4'd1, -1, 0, 1'b0, 7);
        run_valid(4'd0, 4'd15, 4'd3, -1, 0, 1'b0, 91);
        run_valid(4'd2, 4'd5, 4'd1, 1, 0, 1'b0, 9);

        // Rejected commands.
        run_invalid(4'd5, 4'd5, 4'd2);
        run_invalid(4'd3, 4'd7, 4'd0);
        run_invalid(4'd9, 4'd4, 4'd1);

        // Abort in the second DOWN cycle of lo=2, hi=5.
        start = 1'b1; lo = 4'd2; hi = 4'd5; sweeps = 4'd1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        #1;
        chk("abort_en", cnt_en, 1'b0);
        chk("abort_dir", cnt_up, 1'b0);
        chk("abort_pos", pos, 4'd4);
        tick();
        abort = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_pos_frz", pos, 4'd4);
        chk("abort_idx", sweep_idx, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_nodone", done, 1'b0);
        end
        last_pos = 4'd4; last_idx = 4'd0;

        // Abort together with start in IDLE keeps the FSM idle.
        start = 1'b1; abort = 1'b1; lo = 4'd1; hi = 4'd6; sweeps = 4'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        #1;
        chk("abst_busy", busy, 1'b0);
        chk("abst_load", cnt_load, 1'b0);
        tick();
        chk("abst_done", done, 1'b0);
        chk("abst_pos", pos, 4'd4);

        // A fresh start after abort runs normally, here with a count skew.
        run_valid(4'd2, 4'd5, 4'd1, -1, 0, 1'b1, 7);
        run_invalid(4'd7, 4'd2, 4'd3);
        run_valid(4'd1, 4'd4, 4'd2, -1, 20, 1'b0, -1);

        // Reset pulsed during UP.
        start = 1'b1; lo = 4'd3; hi = 4'd9; sweeps = 4'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_up", cnt_up, 1'b1);
        reset = 1'b1;
        #1;
        chk("mrst_en", cnt_en, 1'b0);
        chk("mrst_up", cnt_up, 1'b0);
        chk("mrst_load", cnt_load, 1'b0);
        chk("mrst_pos", pos, 4'd0);
        chk("mrst_idx", sweep_idx, 4'd0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_err", err, 1'b0);
        #1;
        reset = 1'b0;
        exp_err = 1'b0; last_pos = '0; last_idx = '0;
        tick();
        chk("mrst_idle", busy, 1'b0);
        chk("mrst_nodone", done, 1'b0);

        // Randomized runs and occasional rejected commands.
        for (int r = 0; r < 8; r++) begin
            rl = 4'($urandom_range(0, 14));
            rh = 4'($urandom_range(int'(rl) + 1, 15));
            rn = 4'($urandom_range(1, 3));
            run_valid(rl, rh, rn, -1, 25, 1'($urandom_range(0, 1)) && (rh - rl >= 4'd2), -1);
            if ($urandom_range(0, 2) == 0) begin
                rl = 4'($urandom_range(0, 15));
                run_invalid(rl, rl, 4'($urandom_range(1, 15)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
